pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 256, max cycles spent in a wait state before error.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port opcode_i  input  32  instruction currently in ID.
REQ-006 The block SHALL have port ex_load_i  input  1  instruction in EX is a load.
REQ-007 The block SHALL have port ex_rd_i  input  5  destination register of the EX instruction.
REQ-008 The block SHALL have port branch_taken_i  input  1  EX resolved a taken branch/jump.
REQ-009 The block SHALL have port mem_busy_i  input  1  data memory not ready.
REQ-010 The block SHALL have port div_start_i  input  1  multi-cycle divide issued from EX.
REQ-011 The block SHALL have port div_done_i  input  1  divide result available this cycle.
REQ-012 The block SHALL have outputs stall_if_o, stall_id_o, stall_ex_o  output  1 each  hold PC, IF/ID and ID/EX respectively.
REQ-013 The block SHALL have outputs flush_id_o  output  1  squash IF/ID, and bubble_ex_o  output  1  load NOP into ID/EX.
REQ-014 The block SHALL have outputs state_o  output  2  FSM state (RUN=0, MEM_WAIT=1, DIV_WAIT=2, ERROR=3), err_o  output  1  sticky timeout flag, stall_cycles_o  output  CNT_W  stall counter.

Function
REQ-015 The FSM SHALL be registered; stall/flush/bubble outputs SHALL be combinational from state and the current-cycle inputs (zero latency).
REQ-016 RUN priority SHALL be: mem_busy_i > div_start_i > branch_taken_i > load-use; only the highest active source acts.
REQ-017 RUN with mem_busy_i=1 SHALL assert stall_if/id/ex that cycle and go to MEM_WAIT.
REQ-018 MEM_WAIT SHALL assert stall_if/id/ex while mem_busy_i=1; when mem_busy_i=0, stalls deassert that cycle and the FSM returns to RUN.
REQ-019 RUN with div_start_i=1 and mem_busy_i=0 SHALL assert stall_if/id/ex that cycle and go to DIV_WAIT.
REQ-020 DIV_WAIT SHALL assert stall_if/id/ex while div_done_i=0; when div_done_i=1, stalls deassert that cycle and the FSM returns to RUN; mem_busy_i and div_start_i SHALL be ignored in DIV_WAIT.
REQ-021 A wait counter SHALL clear on entry to MEM_WAIT/DIV_WAIT and increment each cycle in them; if it reaches TIMEOUT-1 while the exit condition is false, the FSM SHALL go to ERROR next cycle.
REQ-022 ERROR SHALL assert stall_if/id/ex and err_o continuously; it SHALL be left only by reset.
REQ-023 Branch flush: in RUN with no higher source, branch_taken_i=1 SHALL assert flush_id_o=1 and bubble_ex_o=1 with no stall; branch_taken_i SHALL be ignored in every other state, since EX is held and the branch re-presents.
REQ-024 rs1 (opcode_i[19:15]) SHALL count as used except for opcodes LUI 0110111, AUIPC 0010111 and JAL 1101111.
REQ-025 rs2 (opcode_i[24:20]) SHALL count as used only for opcodes 0110011, 0100011 and 1100011.
REQ-026 Load-use hazard SHALL be ex_load_i=1 and ex_rd_i!=0 and ex_rd_i matches a used source register.
REQ-027 Load-use in RUN with no higher source SHALL assert stall_if_o=1, stall_id_o=1 and bubble_ex_o=1, with stall_ex_o=0 and flush_id_o=0, for that cycle only; no state change.
REQ-028 stall_cycles_o SHALL increment in every cycle with stall_if_o=1 and saturate at all-ones (no wrap).
REQ-029 flush_id_o and bubble_ex_o SHALL never be asserted while stall_ex_o=1.

Reset
REQ-030 reset_i=1 at a clock edge SHALL force state RUN, wait counter 0, err_o=0 and stall_cycles_o=0, from any state including mid-wait and ERROR.
REQ-031 While reset_i=1, all stall, flush and bubble outputs SHALL be 0.

Verification
REQ-032 Load-use: EX lw x5 (ex_load_i=1, ex_rd_i=5), ID add x6,x5,x7 -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, stall_ex=0, stall_cycles_o=1.
REQ-033 No false stall: ex_rd_i=0 in one case, ID opcode LUI with rs1 field=5 in another -> no stall.
REQ-034 mem_busy_i high for 4 cycles from RUN -> stall_if/id/ex=1 for 4 cycles, state_o=1 for cycles 2-5, RUN after, stall_cycles_o=4.
REQ-035 Simultaneous mem_busy_i, branch_taken_i and load-use in RUN -> only the memory stall is applied; flush_id_o=0; after memory completes, branch_taken_i still high -> flush_id_o=1 and bubble_ex_o=1.
REQ-036 TIMEOUT=8, div_start_i then div_done_i never -> ERROR after 8 DIV_WAIT cycles, err_o=1 held; reset_i pulse -> state RUN, err_o=0, counter 0.
REQ-037 Force 2^CNT_W+3 stall cycles -> stall_cycles_o holds at all-ones.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- hazard-controller bundle between the pipeline datapath and
// pipe_ctrl.
//   Datapath -> controller : opcode_i (ID instruction), ex_load_i, ex_rd_i,
//                            branch_taken_i, mem_busy_i, div_start_i, div_done_i
//   Controller -> datapath : stall_if_o, stall_id_o, stall_ex_o, flush_id_o,
//                            bubble_ex_o, state_o, err_o, stall_cycles_o
// The master modport is the datapath side; the slave modport is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      opcode_i;
  logic             ex_load_i;
  logic [4:0]       ex_rd_i;
  logic             branch_taken_i;
  logic             mem_busy_i;
  logic             div_start_i;
  logic             div_done_i;
  logic             stall_if_o;
  logic             stall_id_o;
  logic             stall_ex_o;
  logic             flush_id_o;
  logic             bubble_ex_o;
  logic [1:0]       state_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport master (
    output opcode_i, ex_load_i, ex_rd_i, branch_taken_i, mem_busy_i,
           div_start_i, div_done_i,
    input  stall_if_o, stall_id_o, stall_ex_o, flush_id_o, bubble_ex_o,
           state_o, err_o, stall_cycles_o
  );

  modport slave (
    input  opcode_i, ex_load_i, ex_rd_i, branch_taken_i, mem_busy_i,
           div_start_i, div_done_i,
    output stall_if_o, stall_id_o, stall_ex_o, flush_id_o, bubble_ex_o,
           state_o, err_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller for a 5-stage in-order core.
// Detects load-use hazards, branch flushes, memory waits and multi-cycle
// divides, and drives the stall/flush/bubble controls with zero latency.
// Ports:
//   clk_i    : clock, all state changes on the rising edge
//   reset_i  : synchronous active-high reset
//   bus      : pipe_ctrl_if.slave (pipeline inputs, control/status outputs)
// Parameters:
//   TIMEOUT  : max cycles in MEM_WAIT/DIV_WAIT before entering ERROR
//   CNT_W    : width of the saturating stall-cycle counter (match bus CNT_W)
module pipe_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input logic        clk_i,
  input logic        reset_i,
  pipe_ctrl_if.slave bus
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              err_reg;
  logic [CNT_W-1:0]  stall_cycles_reg;

  logic stall_front;   // PC + IF/ID hold (load-use or full stall)
  logic stall_back;    // ID/EX hold (full stall only)
  logic flush_id;
  logic bubble_ex;

  // Source-register usage decode of the ID instruction.
  logic [6:0] opc;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used, load_use;

  assign opc      = bus.opcode_i[6:0];
  assign rs1      = bus.opcode_i[19:15];
  assign rs2      = bus.opcode_i[24:20];
  assign rs1_used = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  assign rs2_used = (opc == OP_REG) || (opc == OP_STORE) || (opc == OP_BRANCH);
  assign load_use = bus.ex_load_i && (bus.ex_rd_i != 5'd0) &&
                    ((rs1_used && bus.ex_rd_i == rs1) ||
                     (rs2_used && bus.ex_rd_i == rs2));

  // Remaining opcode bits carry no hazard information.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^{bus.opcode_i[31:25], bus.opcode_i[14:7]};

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    stall_front   = 1'b0;
    stall_back    = 1'b0;
    flush_id      = 1'b0;
    bubble_ex     = 1'b0;
    case (state_reg)
      RUN: begin
        // Priority chain: only the highest active source acts.
        if (bus.mem_busy_i) begin
          stall_front   = 1'b1;
          stall_back    = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = '0;
        end else if (bus.div_start_i) begin
          stall_front   = 1'b1;
          stall_back    = 1'b1;
          state_next    = DIV_WAIT;
          wait_cnt_next = '0;
        end else if (bus.branch_taken_i) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (load_use) begin
          // Hold the front end, let the load advance, insert a NOP behind it.
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_busy_i) begin
          stall_front   = 1'b1;
          stall_back    = 1'b1;
          wait_cnt_next = wait_cnt_reg + 1'b1;
          if (wait_cnt_reg == WAIT_LAST) state_next = ERROR;
        end else begin
          state_next = RUN;
        end
      end
      DIV_WAIT: begin
        if (!bus.div_done_i) begin
          stall_front   = 1'b1;
          stall_back    = 1'b1;
          wait_cnt_next = wait_cnt_reg + 1'b1;
          if (wait_cnt_reg == WAIT_LAST) state_next = ERROR;
        end else begin
          state_next = RUN;
        end
      end
      ERROR: begin
        stall_front = 1'b1;
        stall_back  = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
    // Controls are quiet while reset is held, whatever the stale state says.
    if (reset_i) begin
      stall_front = 1'b0;
      stall_back  = 1'b0;
      flush_id    = 1'b0;
      bubble_ex   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg        <= RUN;
      wait_cnt_reg     <= '0;
      err_reg          <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_next == ERROR) err_reg <= 1'b1;
      if (stall_front && (stall_cycles_reg != {CNT_W{1'b1}}))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign bus.stall_if_o     = stall_front;
  assign bus.stall_id_o     = stall_front;
  assign bus.stall_ex_o     = stall_back;
  assign bus.flush_id_o     = flush_id;
  assign bus.bubble_ex_o    = bubble_ex;
  assign bus.state_o        = state_reg;
  assign bus.err_o          = err_reg;
  assign bus.stall_cycles_o = stall_cycles_reg;

endmodule
